// File: rtl/spi_target_regs_if.sv
// SPI target bus bundle: controller-driven serial lines plus the target's
// register-event outputs. The controller (or bench) uses the master view.
interface spi_target_regs_if;
  logic       sclk_i;
  logic       ss_n_i;
  logic       mosi_i;
  logic       miso_o;
  logic       miso_oe_o;
  logic       wr_valid_o;
  logic [6:0] wr_addr_o;
  logic [7:0] wr_data_o;
  logic       rd_valid_o;
  logic       frame_err_o;
  logic [1:0] dbg_state_o;

  modport slave (
    input  sclk_i, ss_n_i, mosi_i,
    output miso_o, miso_oe_o, wr_valid_o, wr_addr_o, wr_data_o,
           rd_valid_o, frame_err_o, dbg_state_o
  );

  modport master (
    output sclk_i, ss_n_i, mosi_i,
    input  miso_o, miso_oe_o, wr_valid_o, wr_addr_o, wr_data_o,
           rd_valid_o, frame_err_o, dbg_state_o
  );
endinterface

// File: rtl/spi_target_regs.sv
// SPI mode-0 target with a byte-wide register file. 16-bit frames:
// {rw, addr[6:0]} then a data byte; reads return mem[addr] on MISO.
module spi_target_regs #(
  parameter int DEPTH = 128
) (
  input  logic         pclk_i,
  input  logic         prst_i,
  spi_target_regs_if.slave bus
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] rx_shift_q, rx_shift_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic       rw_q, rw_d;
  logic [6:0] addr_q, addr_d;
  logic       miso_q, miso_d;
  logic       wr_valid_q, wr_valid_d;
  logic [6:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       rd_valid_q, rd_valid_d;
  logic       frame_err_q, frame_err_d;

  logic sclk_s1_q, sclk_s2_q, sclk_s3_q;
  logic ss_n_s1_q, ss_n_s2_q;
  logic mosi_s1_q, mosi_s2_q;

  logic [7:0] mem_q [DEPTH];
  logic       mem_we;

  logic       sclk_rise, sclk_fall;
  logic [7:0] rx_byte;
  logic [6:0] rd_addr;
  logic [7:0] rd_data;
  logic       addr_ok;

  // Select resets to deasserted so leaving reset never looks like a select.
  always_ff @(posedge pclk_i or posedge prst_i) begin
    if (prst_i) begin
      sclk_s1_q <= 1'b0;
      sclk_s2_q <= 1'b0;
      sclk_s3_q <= 1'b0;
      ss_n_s1_q <= 1'b1;
      ss_n_s2_q <= 1'b1;
      mosi_s1_q <= 1'b0;
      mosi_s2_q <= 1'b0;
    end else begin
      sclk_s1_q <= bus.sclk_i;
      sclk_s2_q <= sclk_s1_q;
      sclk_s3_q <= sclk_s2_q;
      ss_n_s1_q <= bus.ss_n_i;
      ss_n_s2_q <= ss_n_s1_q;
      mosi_s1_q <= bus.mosi_i;
      mosi_s2_q <= mosi_s1_q;
    end
  end

  assign sclk_rise = sclk_s2_q & ~sclk_s3_q;
  assign sclk_fall = ~sclk_s2_q & sclk_s3_q;
  assign rx_byte   = {rx_shift_q, mosi_s2_q};
  assign rd_addr   = rx_byte[6:0];
  assign rd_data   = (int'(rd_addr) < DEPTH) ? mem_q[rd_addr[IW-1:0]] : 8'h00;
  assign addr_ok   = (int'(addr_q) < DEPTH);

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    rw_d        = rw_q;
    addr_d      = addr_q;
    miso_d      = miso_q;
    wr_valid_d  = 1'b0;
    rd_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    mem_we      = 1'b0;

    case (state_q)
      IDLE: begin
        miso_d = 1'b0;
        if (!ss_n_s2_q) begin
          state_d   = ADDR;
          bit_cnt_d = 3'd0;
        end
      end

      ADDR: begin
        if (ss_n_s2_q) begin
          state_d     = IDLE;
          bit_cnt_d   = 3'd0;
          miso_d      = 1'b0;
          frame_err_d = (bit_cnt_q != 3'd0);
        end else if (sclk_rise) begin
          rx_shift_d = rx_byte[6:0];
          if (bit_cnt_q == 3'd7) begin
            rw_d       = rx_byte[7];
            addr_d     = rx_byte[6:0];
            bit_cnt_d  = 3'd0;
            state_d    = DATA;
            tx_shift_d = rx_byte[7] ? 8'h00 : rd_data;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end

      DATA: begin
        // The last data bit wins over a simultaneous deselect.
        if (sclk_rise && (bit_cnt_q == 3'd7)) begin
          rx_shift_d = rx_byte[6:0];
          bit_cnt_d  = 3'd0;
          miso_d     = 1'b0;
          tx_shift_d = 8'h00;
          if (rw_q) begin
            if (addr_ok) begin
              mem_we     = 1'b1;
              wr_valid_d = 1'b1;
              wr_addr_d  = addr_q;
              wr_data_d  = rx_byte;
            end
          end else begin
            rd_valid_d = 1'b1;
          end
          state_d = ss_n_s2_q ? IDLE : ADDR;
        end else if (ss_n_s2_q) begin
          state_d     = IDLE;
          bit_cnt_d   = 3'd0;
          miso_d      = 1'b0;
          frame_err_d = 1'b1;
        end else begin
          if (sclk_rise) begin
            rx_shift_d = rx_byte[6:0];
            bit_cnt_d  = bit_cnt_q + 3'd1;
          end
          if (sclk_fall && !rw_q) begin
            miso_d     = tx_shift_q[7];
            tx_shift_d = {tx_shift_q[6:0], 1'b0};
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk_i or posedge prst_i) begin
    if (prst_i) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      rx_shift_q  <= 7'd0;
      tx_shift_q  <= 8'd0;
      rw_q        <= 1'b0;
      addr_q      <= 7'd0;
      miso_q      <= 1'b0;
      wr_valid_q  <= 1'b0;
      wr_addr_q   <= 7'd0;
      wr_data_q   <= 8'd0;
      rd_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      miso_q      <= miso_d;
      wr_valid_q  <= wr_valid_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      rd_valid_q  <= rd_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_ff @(posedge pclk_i or posedge prst_i) begin
    if (prst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
    end else if (mem_we) begin
      mem_q[addr_q[IW-1:0]] <= rx_byte;
    end
  end

  assign bus.miso_o      = miso_q;
  assign bus.miso_oe_o   = (state_q != IDLE);
  assign bus.wr_valid_o  = wr_valid_q;
  assign bus.wr_addr_o   = wr_addr_q;
  assign bus.wr_data_o   = wr_data_q;
  assign bus.rd_valid_o  = rd_valid_q;
  assign bus.frame_err_o = frame_err_q;
  assign bus.dbg_state_o = state_q;
endmodule
